alu_seq16: RTL and testbench
============================

ALU_SEQ16 -- requirements
Module: alu_seq16

Interface
REQ-001 The module SHALL have a single clock and a reset that is synchronous and active-high, named clk and rst.
REQ-002 Port clk SHALL be an input, 1 bit wide: the rising-edge system clock.
REQ-003 Port rst SHALL be an input, 1 bit wide: synchronous active-high reset.
REQ-004 Port start SHALL be an input, 1 bit wide: request to execute an operation.
REQ-005 Port opcode SHALL be an input, 3 bits wide: operation select.
REQ-006 Port acc_in SHALL be an input, 16 bits wide: the current accumulator value.
REQ-007 Port operand SHALL be an input, 16 bits wide: the memory/immediate operand.
REQ-008 Port result SHALL be an output, 16 bits wide and registered: the value that drives the accumulator data input.
REQ-009 Port acc_load SHALL be an output, 1 bit wide and registered: a one-cycle load strobe to the accumulator.
REQ-010 Port busy SHALL be an output, 1 bit wide: when high, start is not accepted.
REQ-011 Ports zero and carry SHALL be outputs, 1 bit wide each and registered: status flags.

Function
REQ-012 Opcode encoding SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT (acc only), 110 SHL (acc shifted left by 1), 111 MUL.
REQ-013 A start SHALL be accepted only at a rising edge where start=1, busy=0 and rst=0; acc_in, operand and opcode SHALL be latched at that edge.
REQ-014 A start while busy=1 SHALL be ignored, with no state, flag or output change.
REQ-015 The FSM SHALL have exactly two states. IDLE goes to MUL on an accepted MUL. MUL goes to IDLE after the 16th iteration. All other accepted opcodes remain in IDLE.
REQ-016 Non-MUL ops SHALL complete in one cycle: result, flags and acc_load=1 are registered at the accepting edge.
REQ-017 MUL SHALL be a shift-add unsigned multiply with 16 iterations, one per edge. result, flags and acc_load=1 SHALL be registered at the 16th edge after acceptance.
REQ-018 acc_load SHALL be high for exactly one cycle per completed operation and low otherwise; result SHALL hold its value between operations.
REQ-019 busy SHALL equal (state==MUL) OR acc_load, so a new start cannot sample a stale acc_in before the accumulator has loaded.
REQ-020 Arithmetic SHALL be modulo 2^16. For ADD, carry = bit 16 of the 17-bit sum. For SUB, carry = borrow (acc < operand, unsigned). For SHL, carry = acc[15]. For MUL, carry = 1 if bits 31:16 of the 32-bit product are nonzero.
REQ-021 For AND, OR, XOR and NOT, carry SHALL be cleared to 0.
REQ-022 zero SHALL be set to (result==0) on each completion.
REQ-023 Both flags SHALL update only on completion edges and SHALL hold their values otherwise.

Reset
REQ-024 With rst=1 at a rising edge, the module SHALL set state=IDLE, result=0x0000, acc_load=0, zero=0, carry=0 and clear the MUL counter and partial product.
REQ-025 rst asserted mid-MUL SHALL abort the operation with no acc_load pulse and no flag update.
REQ-026 rst SHALL take priority over a simultaneous start.
REQ-027 busy SHALL be 0 in the first cycle after reset.

Structure
REQ-028 Package alu_seq16_pkg SHALL hold WIDTH=16, the opcode constants, the state encodings and MUL_ITER=16.
REQ-029 The shift-add iteration datapath SHALL be the sub-module mul16_shiftadd: a 32-bit partial product, a multiplier shift register and a 5-bit counter, with load/step controls from the FSM.
REQ-030 result and acc_load SHALL connect directly to the accumulator register's data input and load input; the same clk and rst nets SHALL be shared.

Verification
REQ-031 ADD, acc=0x7FFF, op=0x0001 -> one cycle later result=0x8000, acc_load pulse, zero=0, carry=0.
REQ-032 ADD, acc=0xFFFF, op=0x0001 -> result=0x0000, zero=1, carry=1. Then SUB, acc=0x0003, op=0x0005 -> result=0xFFFE, carry=1, zero=0.
REQ-033 MUL, acc=0x0123, op=0x0010 -> busy high for 16 cycles, then result=0x1230 with a single acc_load pulse, carry=0. MUL 0x0100*0x0100 -> result=0x0000, zero=1, carry=1.
REQ-034 start pulsed during MUL cycles 1-15 and during the acc_load cycle -> ignored: the MUL result is unchanged and exactly one acc_load pulse occurs.
REQ-035 rst at MUL cycle 8 -> no acc_load pulse, result=0x0000, flags=0, busy=0 the next cycle. A subsequent AND, acc=0xF0F0, op=0x0FF0 -> result=0x00F0.
REQ-036 Back-to-back SHL on acc=0x8001 -> result=0x0002, carry=1. The earliest accepted next start is 2 cycles after the first.

Source files
------------

// File: rtl/alu_seq16_pkg.sv
// Shared definitions for the sequential 16-bit ALU: widths, opcode
// constants, FSM state encoding and the single-cycle operation helper.
package alu_seq16_pkg;

  localparam int WIDTH    = 16;
  localparam int MUL_ITER = 16;
  localparam int CNT_W    = 5;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] value;
    logic             carry;
  } alu_out_t;

  // Evaluates every opcode that finishes in one cycle. MUL is handled by
  // the iterative datapath, so it yields zero here and is never used.
  function automatic alu_out_t alu_eval(input logic [2:0] op,
                                        input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b);
    alu_out_t   r;
    logic [WIDTH:0] wide;
    r    = '0;
    wide = '0;
    case (op)
      OP_ADD: begin
        wide    = {1'b0, a} + {1'b0, b};
        r.value = wide[WIDTH-1:0];
        r.carry = wide[WIDTH];
      end
      OP_SUB: begin
        // Bit WIDTH of the extended difference is the unsigned borrow.
        wide    = {1'b0, a} - {1'b0, b};
        r.value = wide[WIDTH-1:0];
        r.carry = wide[WIDTH];
      end
      OP_AND: r.value = a & b;
      OP_OR:  r.value = a | b;
      OP_XOR: r.value = a ^ b;
      OP_NOT: r.value = ~a;
      OP_SHL: begin
        r.value = {a[WIDTH-2:0], 1'b0};
        r.carry = a[WIDTH-1];
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mul16_shiftadd.sv
// Shift-add unsigned multiplier datapath, one iteration per step strobe.
// The controlling FSM sees the post-step product combinationally so the
// final result can be registered on the same edge as the last iteration.
module mul16_shiftadd
  import alu_seq16_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product_next,
  output logic                 last
);

  logic [2*WIDTH-1:0] partial;
  logic [2*WIDTH-1:0] addend;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   count;

  // Adds the multiplicand weighted by the current bit position whenever the
  // multiplier bit being examined is set.
  always_comb begin
    addend       = {{WIDTH{1'b0}}, mcand} << count;
    product_next = mplier[0] ? (partial + addend) : partial;
    last         = (count == CNT_W'(MUL_ITER - 1));
  end

  // Operand capture on load, then one shift/accumulate per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      partial <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
    end else if (load) begin
      partial <= '0;
      mcand   <= multiplicand;
      mplier  <= multiplier;
      count   <= '0;
    end else if (step) begin
      partial <= product_next;
      mplier  <= mplier >> 1;
      count   <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq16.sv
// Sequential 16-bit ALU feeding an accumulator. Logic ops, add/sub and
// shift finish at the accepting edge; MUL runs 16 shift-add iterations.
// busy also covers the load-strobe cycle so a following start never sees
// an accumulator value that has not been written back yet.
module alu_seq16
  import alu_seq16_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] result,
  output logic             acc_load,
  output logic             busy,
  output logic             zero,
  output logic             carry
);

  state_t               state;
  state_t               state_next;
  logic                 accept;
  logic                 mul_load;
  logic                 mul_step;
  logic                 mul_last;
  logic [2*WIDTH-1:0]   mul_product;
  alu_out_t             alu_res;

  assign busy    = (state == ST_MUL) | acc_load;
  assign accept  = start & ~busy;
  assign alu_res = alu_eval(opcode, acc_in, operand);

  mul16_shiftadd u_mul (
    .clk          (clk),
    .rst          (rst),
    .load         (mul_load),
    .step         (mul_step),
    .multiplicand (acc_in),
    .multiplier   (operand),
    .product_next (mul_product),
    .last         (mul_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state and multiplier control.
  always_comb begin
    state_next = state;
    mul_load   = 1'b0;
    mul_step   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && (opcode == OP_MUL)) begin
          state_next = ST_MUL;
          mul_load   = 1'b1;
        end
      end
      ST_MUL: begin
        mul_step = 1'b1;
        if (mul_last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Result, flags and load strobe, written only on completion edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      result   <= '0;
      acc_load <= 1'b0;
      zero     <= 1'b0;
      carry    <= 1'b0;
    end else begin
      acc_load <= 1'b0;
      if ((state == ST_IDLE) && accept && (opcode != OP_MUL)) begin
        result   <= alu_res.value;
        carry    <= alu_res.carry;
        zero     <= (alu_res.value == '0);
        acc_load <= 1'b1;
      end else if (mul_step && mul_last) begin
        result   <= mul_product[WIDTH-1:0];
        carry    <= |mul_product[2*WIDTH-1:WIDTH];
        zero     <= (mul_product[WIDTH-1:0] == '0);
        acc_load <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq16.sv
// Self-checking bench for alu_seq16: directed corner cases followed by
// random operations compared against an arithmetic reference model.
module tb_alu_seq16;

  localparam logic [2:0] T_ADD = 3'd0;
  localparam logic [2:0] T_SUB = 3'd1;
  localparam logic [2:0] T_AND = 3'd2;
  localparam logic [2:0] T_SHL = 3'd6;
  localparam logic [2:0] T_MUL = 3'd7;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  opcode;
  logic [15:0] acc_in;
  logic [15:0] operand;
  logic [15:0] result;
  logic        acc_load;
  logic        busy;
  logic        zero;
  logic        carry;

  int nChecks = 0;
  int nFails  = 0;

  alu_seq16 dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .opcode   (opcode),
    .acc_in   (acc_in),
    .operand  (operand),
    .result   (result),
    .acc_load (acc_load),
    .busy     (busy),
    .zero     (zero),
    .carry    (carry)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something never completes.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference behaviour from plain unsigned arithmetic.
  function automatic void refModel(input logic [2:0] op, input logic [15:0] a,
                                   input logic [15:0] b, output logic [15:0] res,
                                   output logic z, output logic c);
    longint unsigned x, y, p;
    x = 64'(a);
    y = 64'(b);
    c = 1'b0;
    case (op)
      3'd0: begin p = x + y; c = (p > 64'd65535); end
      3'd1: begin p = x + 64'd65536 - y; c = (x < y); end
      3'd2: p = x & y;
      3'd3: p = x | y;
      3'd4: p = x ^ y;
      3'd5: p = 64'd65535 - x;
      3'd6: begin p = x * 64'd2; c = (x >= 64'd32768); end
      default: begin p = x * y; c = (p > 64'd65535); end
    endcase
    res = 16'(p % 64'd65536);
    z   = (res == 16'd0);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Waits for the ALU to be free, then presents one start pulse. Returns
  // 1 time unit after the accepting edge with start low; MUL operands are
  // then scrambled to show they were captured at acceptance.
  task automatic applyStimulus(input logic [2:0] op, input logic [15:0] a,
                               input logic [15:0] b);
    int waited = 0;
    @(negedge clk);
    while (busy && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("idle_before_start", 32'(busy), 32'd0);
    start   = 1'b1;
    opcode  = op;
    acc_in  = a;
    operand = b;
    @(posedge clk);
    #1;
    start   = 1'b0;
    acc_in  = 16'($urandom);
    operand = 16'($urandom);
  endtask

  task automatic runOp(input string name, input logic [2:0] op,
                       input logic [15:0] a, input logic [15:0] b);
    logic [15:0] expRes;
    logic        expZ, expC;
    refModel(op, a, b, expRes, expZ, expC);
    applyStimulus(op, a, b);
    if (op == T_MUL) begin
      for (int i = 0; i < 16; i++) begin
        checkOutput({name, ".busy_mul"}, 32'(busy), 32'd1);
        checkOutput({name, ".no_early_load"}, 32'(acc_load), 32'd0);
        @(posedge clk);
        #1;
      end
    end
    checkOutput({name, ".result"}, 32'(result), 32'(expRes));
    checkOutput({name, ".zero"}, 32'(zero), 32'(expZ));
    checkOutput({name, ".carry"}, 32'(carry), 32'(expC));
    checkOutput({name, ".acc_load"}, 32'(acc_load), 32'd1);
    checkOutput({name, ".busy_load"}, 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    checkOutput({name, ".acc_load_drop"}, 32'(acc_load), 32'd0);
    checkOutput({name, ".busy_drop"}, 32'(busy), 32'd0);
    checkOutput({name, ".result_hold"}, 32'(result), 32'(expRes));
    checkOutput({name, ".zero_hold"}, 32'(zero), 32'(expZ));
    checkOutput({name, ".carry_hold"}, 32'(carry), 32'(expC));
  endtask

  initial begin
    int pulses;
    logic [2:0]  rop;
    logic [15:0] ra, rb;

    // Reset with a competing start: reset must win.
    rst     = 1'b1;
    start   = 1'b1;
    opcode  = T_ADD;
    acc_in  = 16'h0001;
    operand = 16'h0001;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.result", 32'(result), 32'h0);
    checkOutput("reset.acc_load", 32'(acc_load), 32'd0);
    checkOutput("reset.zero", 32'(zero), 32'd0);
    checkOutput("reset.carry", 32'(carry), 32'd0);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;

    // Directed arithmetic corners.
    runOp("add_7fff", T_ADD, 16'h7FFF, 16'h0001);
    checkOutput("add_7fff.exact", 32'(result), 32'h8000);
    runOp("add_wrap", T_ADD, 16'hFFFF, 16'h0001);
    checkOutput("add_wrap.exact_zero", 32'(zero), 32'd1);
    runOp("sub_borrow", T_SUB, 16'h0003, 16'h0005);
    checkOutput("sub_borrow.exact", 32'(result), 32'hFFFE);
    runOp("mul_small", T_MUL, 16'h0123, 16'h0010);
    checkOutput("mul_small.exact", 32'(result), 32'h1230);
    runOp("mul_ovf", T_MUL, 16'h0100, 16'h0100);
    checkOutput("mul_ovf.exact_carry", 32'(carry), 32'd1);

    // Starts held through a MUL and its load cycle must all be ignored.
    applyStimulus(T_MUL, 16'h0123, 16'h0010);
    start   = 1'b1;
    opcode  = T_ADD;
    acc_in  = 16'h1111;
    operand = 16'h2222;
    pulses  = 0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      if (acc_load) pulses++;
    end
    checkOutput("mul_ignore.result", 32'(result), 32'h1230);
    checkOutput("mul_ignore.carry", 32'(carry), 32'd0);
    @(posedge clk);
    #1;
    if (acc_load) pulses++;
    start = 1'b0;
    checkOutput("mul_ignore.result_hold", 32'(result), 32'h1230);
    @(posedge clk);
    #1;
    if (acc_load) pulses++;
    checkOutput("mul_ignore.pulses", 32'(pulses), 32'd1);

    // Reset at MUL cycle 8 aborts without a load pulse.
    applyStimulus(T_MUL, 16'h0123, 16'h0010);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort.acc_load", 32'(acc_load), 32'd0);
    checkOutput("abort.result", 32'(result), 32'h0);
    checkOutput("abort.zero", 32'(zero), 32'd0);
    checkOutput("abort.carry", 32'(carry), 32'd0);
    checkOutput("abort.busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (acc_load) pulses++;
    end
    checkOutput("abort.no_pulse", 32'(pulses), 32'd0);
    runOp("and_after_abort", T_AND, 16'hF0F0, 16'h0FF0);
    checkOutput("and_after_abort.exact", 32'(result), 32'h00F0);

    // Back-to-back SHL with start held: second accepted two cycles later.
    @(negedge clk);
    start   = 1'b1;
    opcode  = T_SHL;
    acc_in  = 16'h8001;
    operand = 16'h0000;
    @(posedge clk);
    #1;
    checkOutput("shl1.result", 32'(result), 32'h0002);
    checkOutput("shl1.carry", 32'(carry), 32'd1);
    checkOutput("shl1.acc_load", 32'(acc_load), 32'd1);
    @(negedge clk);
    acc_in = 16'h0002;
    @(posedge clk);
    #1;
    checkOutput("shl_gap.acc_load", 32'(acc_load), 32'd0);
    checkOutput("shl_gap.result", 32'(result), 32'h0002);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("shl2.acc_load", 32'(acc_load), 32'd1);
    checkOutput("shl2.result", 32'(result), 32'h0004);
    checkOutput("shl2.carry", 32'(carry), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("shl2.acc_load_drop", 32'(acc_load), 32'd0);

    // Random operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if (n % 4 == 0) rb = 16'($urandom_range(0, 3));
      if (n % 5 == 0) ra = rb;
      runOp($sformatf("rand%0d_op%0d", n, rop), rop, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
